// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The halt state exists only when IFETCH_MISALIGN_CHECK_EN is defined.
package ifetch_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned OP_LSB     = 0;
   localparam int unsigned OP_W       = 7;
   localparam int unsigned FUNCT3_LSB = 12;
   localparam int unsigned FUNCT3_W   = 3;
   localparam int unsigned FUNCT7_BIT = 30;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
   localparam logic [XLEN-1:0] ALIGN_MASK        = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
`ifdef IFETCH_MISALIGN_CHECK_EN
      S_ISSUE = 2'd2,
      S_HALT  = 2'd3
`else
      S_ISSUE = 2'd2
`endif
   } state_t;

endpackage

// File: rtl/pc_register.sv
// Program counter with +4 adder, target mux and word-alignment handling.
// With IFETCH_MISALIGN_CHECK_EN the raw next PC is loaded and a fault
// indication is exported; otherwise the low two bits are cleared on load.
module pc_register
   import ifetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            pc_src,
   input  logic [XLEN-1:0] pc_target,
   output logic [XLEN-1:0] pc,
`ifdef IFETCH_MISALIGN_CHECK_EN
   output logic            next_misaligned_c,
`endif
   output logic [XLEN-1:0] pc_plus4_c
);

   logic [XLEN-1:0] pc_next_raw;
   logic [XLEN-1:0] pc_next;

   assign pc_plus4_c  = pc + XLEN'(4);
   assign pc_next_raw = pc_src ? pc_target : pc_plus4_c;

`ifdef IFETCH_MISALIGN_CHECK_EN
   assign pc_next           = pc_next_raw;
   assign next_misaligned_c = |pc_next_raw[1:0];
`else
   assign pc_next = pc_next_raw & ALIGN_MASK;
`endif

   // PC updates only on the issue-accept edge
   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= RESET_PC;
      end else if (load) begin
         pc <= pc_next;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, imem request/ready handshake and the
// registered instruction with its decode fields for the control unit.
// Optional feature: IFETCH_MISALIGN_CHECK_EN (sticky misaligned fault + halt).
module instr_fetch
   import ifetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                PCSrc,
   input  logic [XLEN-1:0]     PCTarget,
   input  logic                stall,
   output logic                imem_req,
   output logic [XLEN-1:0]     imem_addr,
   input  logic [XLEN-1:0]     imem_rdata,
   input  logic                imem_ready,
   output logic [XLEN-1:0]     PC,
   output logic [XLEN-1:0]     PCPlus4,
   output logic [XLEN-1:0]     Instr,
   output logic                instr_valid,
   output logic [OP_W-1:0]     op,
   output logic [FUNCT3_W-1:0] funct3,
   output logic                funct7,
   output logic                misaligned
);

   state_t state;
   logic   accept_c;
`ifdef IFETCH_MISALIGN_CHECK_EN
   logic   next_misaligned_c;
`endif

   assign accept_c  = instr_valid & ~stall;
   assign imem_addr = PC;
   assign op        = Instr[OP_LSB +: OP_W];
   assign funct3    = Instr[FUNCT3_LSB +: FUNCT3_W];
   assign funct7    = Instr[FUNCT7_BIT];

   pc_register #(
      .RESET_PC (RESET_PC)
   ) u_pc_register (
      .clk               (clk),
      .reset             (reset),
      .load              (accept_c),
      .pc_src            (PCSrc),
      .pc_target         (PCTarget),
      .pc                (PC),
`ifdef IFETCH_MISALIGN_CHECK_EN
      .next_misaligned_c (next_misaligned_c),
`endif
      .pc_plus4_c        (PCPlus4)
   );

   // Fetch/issue sequencer with registered request, valid and instruction
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         Instr       <= NOP_INSTR;
         instr_valid <= 1'b0;
         imem_req    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               state    <= S_FETCH;
               imem_req <= 1'b1;
            end
            S_FETCH: begin
               if (imem_ready) begin
                  Instr       <= imem_rdata;
                  instr_valid <= 1'b1;
                  imem_req    <= 1'b0;
                  state       <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (!stall) begin
                  Instr       <= NOP_INSTR;
                  instr_valid <= 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
                  if (next_misaligned_c) begin
                     state <= S_HALT;
                  end else begin
                     state    <= S_FETCH;
                     imem_req <= 1'b1;
                  end
`else
                  state    <= S_FETCH;
                  imem_req <= 1'b1;
`endif
               end
            end
`ifdef IFETCH_MISALIGN_CHECK_EN
            S_HALT: begin
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
            end
`endif
            default: begin
               state       <= S_IDLE;
               Instr       <= NOP_INSTR;
               instr_valid <= 1'b0;
               imem_req    <= 1'b0;
            end
         endcase
      end
   end

`ifdef IFETCH_MISALIGN_CHECK_EN
   // Sticky fault on an accept that selects a non-word-aligned next PC
   always_ff @(posedge clk) begin
      if (reset) begin
         misaligned <= 1'b0;
      end else if (accept_c && next_misaligned_c) begin
         misaligned <= 1'b1;
      end
   end
`else
   assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with an expected-instruction
// scoreboard. Honors IFETCH_MISALIGN_CHECK_EN for the misaligned-target step.
module tb_instr_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        reset;
   logic        PCSrc;
   logic [31:0] PCTarget;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic [31:0] PC;
   logic [31:0] PCPlus4;
   logic [31:0] Instr;
   logic        instr_valid;
   logic [6:0]  op;
   logic [2:0]  funct3;
   logic        funct7;
   logic        misaligned;

   int unsigned npass  = 0;
   int unsigned ntotal = 0;
   logic [31:0] sb[$];
   logic [31:0] exp_pc;
   logic [31:0] cur;

   instr_fetch dut (
      .clk         (clk),
      .reset       (reset),
      .PCSrc       (PCSrc),
      .PCTarget    (PCTarget),
      .stall       (stall),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_ready  (imem_ready),
      .PC          (PC),
      .PCPlus4     (PCPlus4),
      .Instr       (Instr),
      .instr_valid (instr_valid),
      .op          (op),
      .funct3      (funct3),
      .funct7      (funct7),
      .misaligned  (misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      return {a[24:0], 7'h33};
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Complete the fetch at exp_pc with ready high; check the issued word
   task automatic capture(input string tag);
      logic [31:0] e;
      check({tag, "_req"}, 32'(imem_req), 32'd1);
      check({tag, "_addr"}, imem_addr, exp_pc);
      sb.push_back(mem_word(exp_pc));
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      check({tag, "_valid"}, 32'(instr_valid), 32'd1);
      check({tag, "_req_off"}, 32'(imem_req), 32'd0);
      check({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         cur = e;
         check({tag, "_instr"}, Instr, e);
         check({tag, "_op"}, 32'(op), 32'(e[6:0]));
         check({tag, "_funct3"}, 32'(funct3), 32'(e[14:12]));
      end
   endtask

   // Accept the issued instruction with the given next-PC selection
   task automatic accept(input string tag, input logic src, input logic [31:0] tgt);
      PCSrc    = src;
      PCTarget = tgt;
      tick();
      exp_pc = (src ? tgt : exp_pc + 32'd4) & 32'hFFFF_FFFC;
      check({tag, "_pc"}, PC, exp_pc);
      check({tag, "_req"}, 32'(imem_req), 32'd1);
      check({tag, "_valid"}, 32'(instr_valid), 32'd0);
      check({tag, "_nop"}, Instr, NOP);
      PCSrc = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      PCSrc      = 1'b0;
      PCTarget   = 32'h0;
      stall      = 1'b0;
      imem_ready = 1'b0;
      cur        = NOP;
      tick();
      tick();
      check("rst_pc", PC, 32'h0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_instr", Instr, NOP);
      check("rst_misaligned", 32'(misaligned), 32'd0);
      check("rst_plus4", PCPlus4, 32'h4);

      // First fetch one cycle after reset release
      reset  = 1'b0;
      exp_pc = 32'h0;
      tick();
      capture("first");
      check("first_op13", 32'(op), 32'h13);
      check("first_f3", 32'(funct3), 32'h0);
      check("first_f7", 32'(funct7), 32'h0);
      accept("seq4", 1'b0, 32'h0);

      // Branch to 0x100, then sequential to 0x104
      capture("f4");
      accept("br100", 1'b1, 32'h100);
      capture("f100");
      accept("seq104", 1'b0, 32'h0);

      // Ready low three cycles: request held stable
      for (int i = 0; i < 3; i++) begin
         tick();
         check("wait_req", 32'(imem_req), 32'd1);
         check("wait_addr", imem_addr, 32'h104);
         check("wait_valid", 32'(instr_valid), 32'd0);
      end
      capture("f104");

      // Stall four cycles while PCSrc toggles; release with PCSrc=1
      stall    = 1'b1;
      PCTarget = 32'h200;
      for (int i = 0; i < 4; i++) begin
         PCSrc = 1'(i % 2);
         tick();
         check("stall_instr", Instr, cur);
         check("stall_pc", PC, 32'h104);
         check("stall_req", 32'(imem_req), 32'd0);
         check("stall_valid", 32'(instr_valid), 32'd1);
      end
      stall = 1'b0;
      accept("rel_tgt", 1'b1, 32'h200);

      // Stall then release with PCSrc=0
      capture("f200");
      stall = 1'b1;
      PCSrc = 1'b1;
      tick();
      tick();
      check("stall2_pc", PC, 32'h200);
      stall = 1'b0;
      accept("rel_seq", 1'b0, 32'h0);

      // Wrap-around from 0xFFFFFFFC
      capture("f204");
      accept("to_top", 1'b1, 32'hFFFF_FFFC);
      check("top_plus4", PCPlus4, 32'h0);
      capture("ftop");
      accept("wrap", 1'b0, 32'h0);

      // Reset while waiting for ready at 0x40
      capture("f0b");
      accept("to40", 1'b1, 32'h40);
      tick();
      tick();
      check("pre_rst_addr", imem_addr, 32'h40);
      reset = 1'b1;
      tick();
      check("mid_rst_pc", PC, 32'h0);
      check("mid_rst_valid", 32'(instr_valid), 32'd0);
      check("mid_rst_req", 32'(imem_req), 32'd0);
      reset  = 1'b0;
      exp_pc = 32'h0;
      tick();
      capture("after_rst");

      // Misaligned target
      PCSrc    = 1'b1;
      PCTarget = 32'h102;
      tick();
      PCSrc = 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
      check("mis_flag", 32'(misaligned), 32'd1);
      check("mis_pc", PC, 32'h102);
      for (int i = 0; i < 3; i++) begin
         imem_ready = 1'b1;
         tick();
         check("halt_req", 32'(imem_req), 32'd0);
         check("halt_valid", 32'(instr_valid), 32'd0);
         check("halt_flag", 32'(misaligned), 32'd1);
      end
      imem_ready = 1'b0;
      reset = 1'b1;
      tick();
      check("halt_rst_flag", 32'(misaligned), 32'd0);
      reset = 1'b0;
      tick();
      check("halt_rst_req", 32'(imem_req), 32'd1);
`else
      check("mis_addr", imem_addr, 32'h100);
      check("mis_flag", 32'(misaligned), 32'd0);
      check("mis_req", 32'(imem_req), 32'd1);
`endif

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly upstream of the control unit in the single-cycle RISC-V core. Holds the program counter, fetches one instruction word per issue from an instruction memory with a ready handshake, and presents `Instr` plus its decoded `op`/`funct3`/`funct7` fields to the control unit. The next-PC update consumes `PCSrc` and `PCTarget`, which the control unit and datapath produce during the issue cycle.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, default 32'h0000_0013: value driven on `Instr` whenever no instruction is valid (`addi x0,x0,0`).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `PCSrc` in 1: 1 selects `PCTarget`, 0 selects `PCPlus4`. Sampled only on the issue-accept edge.
- `PCTarget` in 32: branch/jump target from the datapath.
- `stall` in 1: holds the issued instruction; blocks issue acceptance.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: word address, equal to `PC`.
- `imem_rdata` in 32: instruction word, valid when `imem_ready`=1.
- `imem_ready` in 1: memory response strobe.
- `PC` out 32: current PC.
- `PCPlus4` out 32: `PC`+4, combinational.
- `Instr` out 32: registered instruction.
- `instr_valid` out 1: `Instr` is live for execute.
- `op` out 7: `Instr[6:0]`.
- `funct3` out 3: `Instr[14:12]`.
- `funct7` out 1: `Instr[30]`.
- `misaligned` out 1: sticky fault flag. Present only with the macro; otherwise tied to 0.

## Operation
- States: `S_IDLE`, `S_FETCH`, `S_ISSUE`, and `S_HALT` (macro only).
- `S_IDLE`: outputs quiet. Always moves to `S_FETCH` on the next edge.
- `S_FETCH`: `imem_req`=1 and `imem_addr`=`PC`.
  - On an edge where `imem_ready`=1: capture `Instr` <= `imem_rdata` and go to `S_ISSUE`.
  - Otherwise stay in `S_FETCH` and hold the request.
- `S_ISSUE`: `instr_valid`=1 and `imem_req`=0.
  - Accept condition: `instr_valid` & !`stall`.
  - On accept: `PC` <= `PCSrc` ? `PCTarget` : `PCPlus4`; `Instr` <= `NOP_INSTR`; go to `S_FETCH`.
  - While `stall`=1: `Instr`, `PC` and the state all hold. `PCSrc` and `PCTarget` are ignored.
- Arithmetic: 32-bit adders wrap modulo 2^32. 32'hFFFF_FFFC + 4 = 0 with no flag.
- Fetch-side decode fields are pure slices of `Instr`. They show NOP fields when `instr_valid`=0.
- `imem_ready` is ignored outside `S_FETCH`.

## Timing
- Reset values:
  - State `S_IDLE`; `PC`=`RESET_PC`; `Instr`=`NOP_INSTR`.
  - `instr_valid`=0, `imem_req`=0, `misaligned`=0.
- First `imem_req` appears 1 cycle after `reset` deasserts.
- Latency: if `imem_ready` is high in the first `S_FETCH` cycle, `instr_valid` rises on the next cycle. Minimum issue interval is 2 cycles per instruction. Each ready-wait cycle adds 1.
- Stall while `S_FETCH`: no effect; the fetch completes. The stall takes effect in `S_ISSUE`.
- Reset during `S_FETCH` or `S_ISSUE`: the outstanding request is dropped and the captured `Instr` is discarded. The memory must tolerate an abandoned request.
- `PCSrc` and `stall` both high in `S_ISSUE`: stall wins, and the PC does not update.

## Configuration
- `IFETCH_MISALIGN_CHECK_EN` defined:
  - An accept with the selected next PC having [1:0] != 0 sets `misaligned`=1.
  - `PC` still loads the faulting value, for debug.
  - State goes to `S_HALT`, with `imem_req`=0 and `instr_valid`=0, until `reset`.
- Not defined:
  - Next PC low two bits are forced to 00 on load.
  - `misaligned` is tied to 0 and `S_HALT` does not exist.

## Structure
- Shared package `ifetch_pkg`:
  - State enum.
  - Default `RESET_PC` and `NOP_INSTR` constants.
  - Field-position localparams for `op`, `funct3`, `funct7`.
- One sub-module: `pc_register`. It holds the PC register, the +4 adder, the `PCSrc` mux and the alignment handling, with a load enable driven by the accept condition.

## Test plan
- Reset release, `imem_ready` tied 1, memory returns 32'h00500093 at 0x0:
  - `imem_addr`=0x0 on cycle 1.
  - `instr_valid`=1 on cycle 2 with `op`=7'h13, `funct3`=0.
  - `imem_addr`=0x4 on cycle 3.
- `PCSrc`=1 with `PCTarget`=0x100 on the accept edge -> next `imem_addr`=0x100. `PCSrc`=0 at PC=0x100 -> next `imem_addr`=0x104.
- `imem_ready` low for 3 cycles in `S_FETCH` -> `imem_req` and `imem_addr` stay stable; `instr_valid` rises exactly 1 cycle after `ready`.
- `stall`=1 for 4 cycles in `S_ISSUE` with `PCSrc` toggling -> `Instr` and `PC` frozen, no request. After release, `PC` = `PCPlus4` or `PCTarget` per `PCSrc` on the release edge.
- Reset asserted mid-wait at PC=0x40 -> next cycle `PC`=`RESET_PC`, `instr_valid`=0, `imem_req`=0, then a fetch from 0x0.
- `PCTarget`=0x102 with `PCSrc`=1:
  - With the macro: `misaligned`=1, `imem_req` stays 0 until reset.
  - Without the macro: next `imem_addr`=0x100.
